// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer, elastic valid/ready on both sides and flush.
// Optional back-pressure counter on stallCnt when PERF_CNT_EN is defined; otherwise stallCnt is tied to 0.
module ex_mem_skid_reg #(
  parameter int DATA_W      = 32,
  parameter int INS_ADDRESS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      aluResultIn,
  input  logic [DATA_W-1:0]      regData2In,
  input  logic [4:0]             regDstIn,
  input  logic [2:0]             funct3In,
  input  logic [INS_ADDRESS-1:0] PCin,
  input  logic                   MemWrtEnIn,
  input  logic                   MemRdEnIn,
  input  logic                   RegWrtEnIn,
  input  logic [2:0]             RegWrtSrcIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      aluResultOut,
  output logic [DATA_W-1:0]      regData2Out,
  output logic [4:0]             regDstOut,
  output logic [2:0]             funct3Out,
  output logic [INS_ADDRESS-1:0] PCout,
  output logic                   MemWrtEnOut,
  output logic                   MemRdEnOut,
  output logic                   RegWrtEnOut,
  output logic [2:0]             RegWrtSrcOut,
  output logic [15:0]            stallCnt
);

  typedef struct packed {
    logic [DATA_W-1:0]      alu_result;
    logic [DATA_W-1:0]      reg_data2;
    logic [4:0]             reg_dst;
    logic [2:0]             funct3;
    logic [INS_ADDRESS-1:0] pc;
    logic                   mem_wrt_en;
    logic                   mem_rd_en;
    logic                   reg_wrt_en;
    logic [2:0]             reg_wrt_src;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_bundle;
  logic    in_xfer, out_xfer;

  assign in_bundle = '{alu_result: aluResultIn, reg_data2: regData2In, reg_dst: regDstIn,
                       funct3: funct3In, pc: PCin, mem_wrt_en: MemWrtEnIn,
                       mem_rd_en: MemRdEnIn, reg_wrt_en: RegWrtEnIn,
                       reg_wrt_src: RegWrtSrcIn};

  // Both handshake outputs come straight from the state flop, so neither side sees a comb path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (in_xfer) begin
        main_d  = in_bundle;
        state_d = ONE;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_bundle;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          skid_d  = in_bundle;
          state_d = FULL;
        end
      end
      FULL: if (out_xfer) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards whatever arrives this cycle; main keeps its last payload so outputs stay quiet.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // NOTE: the payload registers are reset too, because the data outputs must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign aluResultOut = main_q.alu_result;
  assign regData2Out  = main_q.reg_data2;
  assign regDstOut    = main_q.reg_dst;
  assign funct3Out    = main_q.funct3;
  assign PCout        = main_q.pc;
  assign RegWrtSrcOut = main_q.reg_wrt_src;
  assign MemWrtEnOut  = main_q.mem_wrt_en & out_valid;
  assign MemRdEnOut   = main_q.mem_rd_en  & out_valid;
  assign RegWrtEnOut  = main_q.reg_wrt_en & out_valid;

`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stallCnt = stall_cnt_q;
`else
  assign stallCnt = 16'h0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed self-checking bench for ex_mem_skid_reg: streaming, back-pressure, flush, gating, async reset.
`timescale 1ns/1ps
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] aluResultIn, regData2In, aluResultOut, regData2Out;
  logic [4:0]  regDstIn, regDstOut;
  logic [2:0]  funct3In, funct3Out, RegWrtSrcIn, RegWrtSrcOut;
  logic [8:0]  PCin, PCout;
  logic        MemWrtEnIn, MemRdEnIn, RegWrtEnIn;
  logic        MemWrtEnOut, MemRdEnOut, RegWrtEnOut;
  logic [15:0] stallCnt;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_skid_reg #(.DATA_W(32), .INS_ADDRESS(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .aluResultIn(aluResultIn), .regData2In(regData2In), .regDstIn(regDstIn),
    .funct3In(funct3In), .PCin(PCin), .MemWrtEnIn(MemWrtEnIn), .MemRdEnIn(MemRdEnIn),
    .RegWrtEnIn(RegWrtEnIn), .RegWrtSrcIn(RegWrtSrcIn), .out_valid(out_valid),
    .out_ready(out_ready), .aluResultOut(aluResultOut), .regData2Out(regData2Out),
    .regDstOut(regDstOut), .funct3Out(funct3Out), .PCout(PCout),
    .MemWrtEnOut(MemWrtEnOut), .MemRdEnOut(MemRdEnOut), .RegWrtEnOut(RegWrtEnOut),
    .RegWrtSrcOut(RegWrtSrcOut), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven and outputs sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    aluResultIn = '0; regData2In = '0; regDstIn = '0; funct3In = '0; PCin = '0;
    MemWrtEnIn = 1'b0; MemRdEnIn = 1'b0; RegWrtEnIn = 1'b0; RegWrtSrcIn = '0;
    #2;
    apply_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_out", aluResultOut, 0);
    check("rst_memwr", MemWrtEnOut, 0);
    check("rst_stall", stallCnt, 0);

    // 1: stream, 1-cycle latency, in_ready stays high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      aluResultIn = 32'(i);
      regDstIn    = 5'(i + 3);
      PCin        = 9'(i * 4);
      step();
      check("stream_valid", out_valid, 1);
      check("stream_alu", aluResultOut, 64'(i));
      check("stream_rd", regDstOut, 64'(i + 3));
      check("stream_pc", PCout, 64'(i * 4));
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", out_valid, 0);

    // 2: back-pressure fills both entries, then drains A then B
    out_ready = 1'b0;
    in_valid = 1'b1; aluResultIn = 32'h10; regData2In = 32'hA0;
    step();
    check("bp_a_valid", out_valid, 1);
    check("bp_a_in_ready", in_ready, 1);
    aluResultIn = 32'h20; regData2In = 32'hB0;
    step();
    check("bp_full_in_ready", in_ready, 0);
    check("bp_hold_a", aluResultOut, 32'h10);
    aluResultIn = 32'h99;
    step();
    check("bp_still_a", aluResultOut, 32'h10);
    check("bp_still_full", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_b_valid", out_valid, 1);
    check("bp_b_alu", aluResultOut, 32'h20);
    check("bp_b_data2", regData2Out, 32'hB0);
    check("bp_b_in_ready", in_ready, 1);
    step();
    check("bp_no_dup", out_valid, 0);

    // 3: flush while FULL with an incoming C
    out_ready = 1'b0; in_valid = 1'b1;
    aluResultIn = 32'h11; step();
    aluResultIn = 32'h12; step();
    check("fl_full", in_ready, 0);
    flush = 1'b1; aluResultIn = 32'h30;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_data_held", aluResultOut, 32'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_c", out_valid, 0);
    end

    // 4: control gating by out_valid
    in_valid = 1'b1; MemWrtEnIn = 1'b1; RegWrtEnIn = 1'b1; MemRdEnIn = 1'b1;
    RegWrtSrcIn = 3'd5; aluResultIn = 32'h40;
    step();
    check("gt_memwr_on", MemWrtEnOut, 1);
    check("gt_regwr_on", RegWrtEnOut, 1);
    check("gt_src", RegWrtSrcOut, 5);
    in_valid = 1'b0;
    step();
    check("gt_valid_off", out_valid, 0);
    check("gt_memwr_off", MemWrtEnOut, 0);
    check("gt_memrd_off", MemRdEnOut, 0);
    check("gt_regwr_off", RegWrtEnOut, 0);
    MemWrtEnIn = 1'b0; RegWrtEnIn = 1'b0; MemRdEnIn = 1'b0;

    // 5: asynchronous reset mid-FULL, observed before the next edge
    out_ready = 1'b0; in_valid = 1'b1;
    aluResultIn = 32'h50; step();
    aluResultIn = 32'h60; step();
    in_valid = 1'b0;
    check("ar_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_alu_zero", aluResultOut, 0);
    #1 rst = 1'b0;
    step();
    check("ar_stays_empty", out_valid, 0);

    // 6: stall counter
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; aluResultIn = 32'h70;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
`ifdef PERF_CNT_EN
    check("pc_five", stallCnt, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pc_flush_no_inc", stallCnt, 5);
`else
    check("pc_tied_zero", stallCnt, 0);
`endif
    check("pc_held_valid", aluResultOut, 32'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000ns");
    $fatal(1);
  end

endmodule
